// File: rtl/md_iter_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package md_iter_unit_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } md_state_e;

    // Divide-by-zero result: every bit of lo takes this value, hi returns the dividend.
    localparam logic DIV0_LO_FILL = 1'b1;

    // Default operand width.
    localparam int unsigned MD_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result signs.
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? ({WIDTH{1'b0}} - val) : val;

endmodule

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit: one bit per cycle on magnitudes, signs applied at the end.
module md_iter_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_mult,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import md_iter_unit_pkg::*;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [WIDTH-1:0]   mag_q;
    // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic               is_mult_q, is_unsigned_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic               neg_res, neg_rem;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;
    logic [WIDTH-1:0]   hi_d, lo_d;

    md_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
        .neg (~is_unsigned & op_a[WIDTH-1]),
        .val (op_a),
        .res (mag_a)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
        .neg (~is_unsigned & op_b[WIDTH-1]),
        .val (op_b),
        .res (mag_b)
    );

    assign neg_res = ~is_unsigned_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign neg_rem = ~is_unsigned_q & a_q[WIDTH-1];

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg (neg_res),
        .val (acc_q),
        .res (prod_fixed)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .neg (neg_res),
        .val (acc_q[WIDTH-1:0]),
        .res (quo_fixed)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .neg (neg_rem),
        .val (acc_q[2*WIDTH-1:WIDTH]),
        .res (rem_fixed)
    );

    // One iteration step for both operations.
    always_comb begin
        // Shift-add: add multiplicand when the current multiplier bit is set, then shift right.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        // Restoring divide: shift next dividend bit into remainder, subtract if it fits.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mag_q};
        div_diff  = div_shift - {1'b0, mag_q};
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    // Signed result fix-up, selected by operation and divide-by-zero.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_mult_q) begin
            {hi_d, lo_d} = prod_fixed;
        end else if (b_q == {WIDTH{1'b0}}) begin
            lo_d = {WIDTH{DIV0_LO_FILL}};
            hi_d = a_q;
        end else begin
            lo_d = quo_fixed;
            hi_d = rem_fixed;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        unique case (state_q)
            StIdle: if (start) state_d = (!is_mult && op_b == {WIDTH{1'b0}}) ? StFix : StCalc;
            StCalc: if (cnt_q == LAST) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            mag_q         <= '0;
            acc_q         <= '0;
            is_mult_q     <= 1'b0;
            is_unsigned_q <= 1'b0;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q           <= op_a;
                        b_q           <= op_b;
                        is_mult_q     <= is_mult;
                        is_unsigned_q <= is_unsigned;
                        cnt_q         <= '0;
                        mag_q         <= is_mult ? mag_a : mag_b;
                        acc_q         <= {{WIDTH{1'b0}}, (is_mult ? mag_b : mag_a)};
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= is_mult_q ? mul_next : div_next;
                end
                StFix: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed self-checking bench for md_iter_unit (WIDTH = 32).
module tb_md_iter_unit;

    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             is_mult = 1'b0;
    logic             is_unsigned = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    md_iter_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_mult     (is_mult),
        .is_unsigned (is_unsigned),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, optionally inject a second start at cycle 10, and check the result.
    task automatic run_op(input string tag, input logic m, input logic u,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input bit poke);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1; is_mult = m; is_unsigned = u; op_a = a; op_b = b;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (poke && n == 10) begin
                start = 1'b1; is_mult = 1'b0; is_unsigned = 1'b1;
                op_a = 32'hDEAD_BEEF; op_b = 32'h0;
            end
            if (poke && n == 11) start = 1'b0;
            if (done) seen = 1'b1;
            else check({tag, " busy"}, 64'(busy), 64'd1);
        end
        check({tag, " latency"}, 64'(n), 64'(elat));
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
        check({tag, " hold"}, {hi, lo}, {ehi, elo});
    endtask

    initial begin
        int n;
        int pulses;

        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("smul -3*5", 1, 0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT, 0);
        run_op("umul max", 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               LAT, 0);
        run_op("smul -3*-5", 1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15, LAT, 0);
        run_op("sdiv -7/2", 0, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT, 0);
        run_op("sdiv 7/-2", 0, 0, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, LAT, 0);
        run_op("udiv 100/7", 0, 1, 32'd100, 32'd7, 32'd2, 32'hE, LAT, 0);
        run_op("udiv by 0", 0, 1, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 2, 0);
        run_op("sdiv by 0", 0, 0, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 2, 0);
        run_op("sdiv minneg/-1", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
               LAT, 0);
        run_op("busy start", 1, 1, 32'd6, 32'd7, 32'h0, 32'd42, LAT, 1);

        // Abort a multiply with a reset pulse at cycle 20.
        @(negedge clk);
        start = 1'b1; is_mult = 1'b1; is_unsigned = 1'b1; op_a = 32'd3; op_b = 32'd9;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done || busy) pulses++;
        end
        check("abort no done", 64'(pulses), 64'd0);

        run_op("after reset", 1, 1, 32'd3, 32'd9, 32'h0, 32'd27, LAT, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_iter_unit.md
MD_ITER_UNIT -- requirements
Module: md_iter_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; iteration count equals WIDTH.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1: operation request, sampled only in IDLE.
REQ-005 SHALL have port is_mult  input  1: 1 = multiply, 0 = divide; driven by control-unit md_is_mult.
REQ-006 SHALL have port is_unsigned  input  1: 1 = MULTU/DIVU, 0 = signed; driven by control-unit md_is_unsigned.
REQ-007 SHALL have port op_a  input  WIDTH: multiplicand or dividend (rs).
REQ-008 SHALL have port op_b  input  WIDTH: multiplier or divisor (rt).
REQ-009 SHALL have port busy  output  1: high in every state except IDLE.
REQ-010 SHALL have port done  output  1: one-cycle pulse when hi/lo become valid.
REQ-011 SHALL have port hi  output  WIDTH: product upper half or remainder.
REQ-012 SHALL have port lo  output  WIDTH: product lower half or quotient.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-014 IDLE with start=1 at an edge SHALL latch op_a, op_b, is_mult, is_unsigned, convert signed operands to magnitudes, clear the iteration counter and enter CALC.
REQ-015 CALC SHALL run exactly WIDTH cycles, one bit per cycle: multiply as radix-2 shift-add on magnitudes into a 2*WIDTH accumulator; divide as restoring shift-subtract producing one quotient bit per cycle.
REQ-016 FIX SHALL apply signs in one cycle: signed product negated when op_a[MSB]^op_b[MSB]; signed quotient negated when signs differ; signed remainder takes the sign of op_a.
REQ-017 DONE SHALL last one cycle with done=1 and hi/lo already valid, then return to IDLE.
REQ-018 Latency SHALL be WIDTH+2 edges from the accepting edge to the done pulse (34 for WIDTH=32); throughput one operation per WIDTH+3 cycles.
REQ-019 hi/lo SHALL update only on the FIX->DONE edge and hold until the next completion or reset.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands or progress.
REQ-021 Divide with op_b=0 SHALL skip CALC (IDLE -> FIX -> DONE) and return lo = all ones, hi = op_a, for both signed and unsigned.
REQ-022 Signed divide of most-negative by -1 SHALL return lo = 0x80000000 and hi = 0 (WIDTH=32), with no trap.
REQ-023 All arithmetic SHALL be modulo 2^WIDTH per result half; no overflow flag.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear the operand registers.
REQ-025 Reset mid-operation SHALL abort the operation with no done pulse; the first edge after release SHALL accept a new start.

Structure
REQ-026 State encodings (IDLE/CALC/FIX/DONE) and the div-by-zero result constants SHALL live in the shared definition header alongside the data-type definitions.
REQ-027 One sub-module, md_sign_fix (combinational conditional two's-complement negate for WIDTH and 2*WIDTH values), is natural and SHALL be reused for operand magnitude and result fix-up.

Verification
REQ-028 Signed mult: start, a=0xFFFFFFFD (-3), b=5 -> done 34 cycles later, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-029 Unsigned mult: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 Divide: signed a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned a=100, b=7 -> lo=0xE, hi=0x2.
REQ-031 Boundary divide: a=0x12345678, b=0 -> done 2 cycles after start, lo=0xFFFFFFFF, hi=0x12345678; signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 Busy start and reset: second start at cycle 10 of a mult -> ignored, first result intact; rst pulse at cycle 20 -> busy=0, hi=lo=0, no done pulse; a new start then completes normally.
